target_unpacket: RTL and testbench
==================================

# target_unpacket

Receive-side counterpart of the target packetizer. It accepts the 32-bit AXI-Stream target packet stream, checks and parses the 4-word header, and reassembles each `CELL_LENGTH`-word cell into one `INFO_BITS` target record. It emits end-of-frame when a packet with `has_more=0` completes, and discards malformed packets. It sits after the network/DMA receive path and feeds target-overlay or host-side logic.

## Interface
- `MAX_PER_PACKET`, 90, largest legal `chunk_length`; larger values are a header error.
- `INFO_BITS`, 128, record width; must be an integer multiple of `DATA_BITS`.
- `DATA_BITS`, 32, stream word width; the header layout requires 32.
- `SYNC_WORD`, 32'h1aa11ff1, header word 0.
- `aclk` in 1: single clock, rising edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `packet_tdata` in `DATA_BITS`; `packet_tvalid` in 1; `packet_tlast` in 1: AXI-S slave input.
- `packet_tready` out 1: AXI-S slave ready.
- `target_info` out `INFO_BITS`: reassembled record.
- `target_valid` out 1; `target_ready` in 1: record handshake.
- `target_eof` out 1: one-cycle pulse; the frame is complete.
- `timestamp` out `DATA_BITS`; `hsize` out 16; `vsize` out 16: header fields of the current packet.
- `err_pulse` out 1: one cycle per detected error.
- `err_count` out 16: errors since reset, saturating at 16'hFFFF.

## Operation
- `CELL_LENGTH = INFO_BITS/DATA_BITS`. A word transfers when `packet_tvalid && packet_tready`.
- Header words:
  - w0 = `SYNC_WORD`.
  - w1 = timestamp.
  - w2: [15:0] `chunk_length`, [16] `has_more`, [31:17] ignored.
  - w3: [31:16] hsize, [15:0] vsize.
- Cell words arrive LSW first; word k fills `target_info[k*DATA_BITS +: DATA_BITS]`.
- State machine:
  - **HUNT**: compare each accepted word with `SYNC_WORD`.
    - Match with tlast=0 → HDR.
    - Match with tlast=1 → error, stay in HUNT.
    - Mismatch → discard silently (no error) and stay in HUNT.
  - **HDR**: word counter runs 1..3.
    - w1 loads `timestamp`. w2 latches `chunk_length` and `has_more`. w3 loads `hsize`/`vsize`.
    - `chunk_length > MAX_PER_PACKET` at w2 → error; on tlast → HUNT, else → DROP.
    - tlast on w1/w2 → error, → HUNT.
    - At w3, tlast is expected iff `chunk_length==0`.
      - Expected and present → HUNT, and arm eof if `has_more==0`.
      - tlast present but `chunk_length!=0` → error, → HUNT.
      - tlast missing but `chunk_length==0` → error, → DROP.
      - Otherwise → DATA with `cell_cnt=0`, `word_cnt=0`.
  - **DATA**: shift words into the assembly register.
    - On `word_cnt==CELL_LENGTH-1`, load the output register and increment `cell_cnt`.
    - The last word of cell `chunk_length-1` must carry tlast. If so → HUNT, and arm eof if `has_more==0`.
    - tlast on any other word → error, partial cell dropped, → HUNT.
    - Missing tlast on the final word → error, final cell still delivered, → DROP.
  - **DROP**: accept and discard words until tlast, then → HUNT.
- Eof:
  - "Arm eof" sets `eof_pend`.
  - `target_eof` pulses in the first cycle with `eof_pend && !target_valid`; `eof_pend` clears in the same cycle.
  - This guarantees eof follows the frame's final record.
- Errors: every error listed above pulses `err_pulse` and increments `err_count`.

## Timing
- **Reset** (async assert): state HUNT, `target_valid=0`, `target_eof=0`, `err_pulse=0`, `err_count=0`, `timestamp/hsize/vsize/target_info=0`, `eof_pend=0`. `packet_tready=0` while `aresetn` is low.
- **packet_tready**: combinational from registered state only, never from `packet_tvalid`.
  - 1 in HUNT, HDR and DROP.
  - In DATA it is 1 except on the last word of a cell while `(target_valid && !target_ready) || eof_pend`.
- **Latency**: `target_valid` rises the cycle after the last word of a cell is accepted. A full cell can be handed off every `CELL_LENGTH` cycles with no bubble.
- **Output hold**: `target_valid`/`target_info` hold until `target_ready`. A same-cycle consume and new load keeps valid high with the new data.
- **Header outputs**: `timestamp/hsize/vsize` update the cycle after their word is accepted and hold until the next header.
- **Eof timing**: `target_eof` is earliest 1 cycle after tlast when no record is pending; otherwise it comes 1 cycle after the final record is consumed.
- **Reset mid-packet**: all state is discarded and reception restarts in HUNT.

## Structure
- Shared package `target_packet_pkg`:
  - `SYNC_WORD`, `HEADER_LENGTH=4`.
  - Header word indices and field bit positions (`LEN_LSB=0`, `LEN_MSB=15`, `MORE_BIT=16`, `HSIZE_LSB=16`).
  - `clogb2` function.
  - These are shared with the packetizer.
- Single module, no sub-module. The FSM, word/cell counters, assembly register and output register live together.

## Test plan
- Packet with ts=0x12345678, len=2, has_more=0, hsize=1920, vsize=1080, cells A,B → records A then B, `timestamp=0x12345678`, `hsize=0x0780`, `vsize=0x0438`, one `target_eof` after B, `err_count=0`.
- Two back-to-back packets, 90 cells with has_more=1, then 3 cells with has_more=0 → 93 records in order, exactly one eof after record 93.
- Header-only packet, len=0 and has_more=0, tlast on w3 → no record, `target_eof` 1 cycle after tlast.
- `target_ready` held low for 20 cycles mid-packet → `packet_tready` drops on the next cell's last word, no data lost, records and eof in order.
- Garbage words 0xDEADBEEF ×3 before sync → silently skipped, no error. Packet with len=95 → `err_pulse`, DROP to tlast, `err_count=1`.
- Early tlast on word 2 of cell 1 (len=3) → `err_pulse`, only cell 0 delivered, no eof. The next valid packet parses normally.

Source files
------------

// File: rtl/target_packet_pkg.sv
// Header layout, state encoding and sizing helper shared by the target packetizer
// and the target unpacketizer.
package target_packet_pkg;

    localparam logic [31:0] SYNC_WORD     = 32'h1aa1_1ff1;
    localparam int          HEADER_LENGTH = 4;

    localparam int HDR_SYNC_IDX = 0;
    localparam int HDR_TS_IDX   = 1;
    localparam int HDR_LEN_IDX  = 2;
    localparam int HDR_SIZE_IDX = 3;

    localparam int LEN_LSB   = 0;
    localparam int LEN_MSB   = 15;
    localparam int MORE_BIT  = 16;
    localparam int HSIZE_LSB = 16;
    localparam int HSIZE_MSB = 31;
    localparam int VSIZE_LSB = 0;
    localparam int VSIZE_MSB = 15;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } unpack_state_e;

    function automatic int clogb2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/target_unpacket.sv
// Receive-side target packet parser: validates the 4-word header, reassembles
// CELL_LENGTH-word cells into records, flags end-of-frame and counts malformed packets.
module target_unpacket
    import target_packet_pkg::*;
#(
    parameter int          MAX_PER_PACKET = 90,
    parameter int          INFO_BITS      = 128,
    parameter int          DATA_BITS      = 32,
    parameter logic [31:0] SYNC_WORD      = target_packet_pkg::SYNC_WORD
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [DATA_BITS-1:0] packet_tdata,
    input  logic                 packet_tvalid,
    input  logic                 packet_tlast,
    output logic                 packet_tready,
    output logic [INFO_BITS-1:0] target_info,
    output logic                 target_valid,
    input  logic                 target_ready,
    output logic                 target_eof,
    output logic [DATA_BITS-1:0] timestamp,
    output logic [15:0]          hsize,
    output logic [15:0]          vsize,
    output logic                 err_pulse,
    output logic [15:0]          err_count
);

    localparam int CELL_LENGTH = INFO_BITS / DATA_BITS;
    localparam int WC_W        = (CELL_LENGTH > 1) ? clogb2(CELL_LENGTH) : 1;
    localparam int HC_W        = clogb2(HEADER_LENGTH);
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(CELL_LENGTH - 1);

    unpack_state_e          state_q,     state_d;
    logic [HC_W-1:0]        hdr_cnt_q,   hdr_cnt_d;
    logic [WC_W-1:0]        word_cnt_q,  word_cnt_d;
    logic [15:0]            cell_cnt_q,  cell_cnt_d;
    logic [15:0]            chunk_len_q, chunk_len_d;
    logic                   has_more_q,  has_more_d;
    logic [INFO_BITS-1:0]   asm_q,       asm_d;
    logic [INFO_BITS-1:0]   info_q,      info_d;
    logic                   valid_q,     valid_d;
    logic                   eof_q,       eof_d;
    logic                   eof_pend_q,  eof_pend_d;
    logic                   err_q,       err_d;
    logic [15:0]            err_cnt_q,   err_cnt_d;
    logic [DATA_BITS-1:0]   ts_q,        ts_d;
    logic [15:0]            hsize_q,     hsize_d;
    logic [15:0]            vsize_q,     vsize_d;

    logic        ready_s;
    logic        accept_s;
    logic        load_s;
    logic        arm_s;
    logic        pend_s;
    logic        cell_end_s;
    logic        final_s;
    logic [15:0] len_s;

    // Back-pressure: only the cell-completing word can stall, so the output register never overflows.
    always_comb begin
        if ((state_q == ST_DATA) && (word_cnt_q == LAST_WORD) &&
            ((valid_q && !target_ready) || eof_pend_q)) begin
            ready_s = 1'b0;
        end else begin
            ready_s = 1'b1;
        end
    end

    assign packet_tready = aresetn & ready_s;
    assign accept_s      = packet_tvalid & packet_tready;
    assign len_s         = packet_tdata[LEN_MSB:LEN_LSB];
    assign cell_end_s    = (word_cnt_q == LAST_WORD);
    assign final_s       = cell_end_s && (cell_cnt_q == (chunk_len_q - 16'd1));

    // Packet parser: header checks, cell assembly and malformed-packet recovery.
    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        word_cnt_d  = word_cnt_q;
        cell_cnt_d  = cell_cnt_q;
        chunk_len_d = chunk_len_q;
        has_more_d  = has_more_q;
        asm_d       = asm_q;
        ts_d        = ts_q;
        hsize_d     = hsize_q;
        vsize_d     = vsize_q;
        load_s      = 1'b0;
        arm_s       = 1'b0;
        err_d       = 1'b0;
        if (accept_s) begin
            case (state_q)
                ST_HUNT: begin
                    if (packet_tdata != SYNC_WORD) begin
                        state_d = ST_HUNT;
                    end else if (packet_tlast) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = ST_HDR;
                        hdr_cnt_d = HC_W'(HDR_SYNC_IDX + 1);
                    end
                end
                ST_HDR: begin
                    case (hdr_cnt_q)
                        HC_W'(HDR_TS_IDX): begin
                            ts_d = packet_tdata;
                            if (packet_tlast) begin
                                err_d   = 1'b1;
                                state_d = ST_HUNT;
                            end else begin
                                hdr_cnt_d = HC_W'(HDR_LEN_IDX);
                            end
                        end
                        HC_W'(HDR_LEN_IDX): begin
                            chunk_len_d = len_s;
                            has_more_d  = packet_tdata[MORE_BIT];
                            if (len_s > 16'(MAX_PER_PACKET)) begin
                                err_d   = 1'b1;
                                state_d = packet_tlast ? ST_HUNT : ST_DROP;
                            end else if (packet_tlast) begin
                                err_d   = 1'b1;
                                state_d = ST_HUNT;
                            end else begin
                                hdr_cnt_d = HC_W'(HDR_SIZE_IDX);
                            end
                        end
                        HC_W'(HDR_SIZE_IDX): begin
                            hsize_d = packet_tdata[HSIZE_MSB:HSIZE_LSB];
                            vsize_d = packet_tdata[VSIZE_MSB:VSIZE_LSB];
                            if (packet_tlast && (chunk_len_q == 16'd0)) begin
                                state_d = ST_HUNT;
                                arm_s   = !has_more_q;
                            end else if (packet_tlast) begin
                                err_d   = 1'b1;
                                state_d = ST_HUNT;
                            end else if (chunk_len_q == 16'd0) begin
                                err_d   = 1'b1;
                                state_d = ST_DROP;
                            end else begin
                                state_d    = ST_DATA;
                                cell_cnt_d = 16'd0;
                                word_cnt_d = '0;
                            end
                        end
                        default: begin
                            state_d = ST_HUNT;
                        end
                    endcase
                end
                ST_DATA: begin
                    asm_d[int'(word_cnt_q) * DATA_BITS +: DATA_BITS] = packet_tdata;
                    if (cell_end_s) begin
                        load_s     = 1'b1;
                        word_cnt_d = '0;
                        cell_cnt_d = cell_cnt_q + 16'd1;
                    end else begin
                        word_cnt_d = word_cnt_q + WC_W'(1);
                    end
                    if (final_s) begin
                        if (packet_tlast) begin
                            state_d = ST_HUNT;
                            arm_s   = !has_more_q;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_DROP;
                        end
                    end else if (packet_tlast) begin
                        err_d   = 1'b1;
                        state_d = ST_HUNT;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DROP: begin
                    if (packet_tlast) begin
                        state_d = ST_HUNT;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output record, end-of-frame sequencing and error accounting.
    always_comb begin
        info_d = info_q;
        if (load_s) begin
            valid_d = 1'b1;
            info_d  = asm_d;
        end else if (target_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        // eof waits until the frame's last record has left the output register
        pend_s = eof_pend_q | arm_s;
        if (pend_s && !valid_d) begin
            eof_d      = 1'b1;
            eof_pend_d = 1'b0;
        end else begin
            eof_d      = 1'b0;
            eof_pend_d = pend_s;
        end

        if (err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State and output registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_HUNT;
            hdr_cnt_q   <= '0;
            word_cnt_q  <= '0;
            cell_cnt_q  <= 16'd0;
            chunk_len_q <= 16'd0;
            has_more_q  <= 1'b0;
            asm_q       <= '0;
            info_q      <= '0;
            valid_q     <= 1'b0;
            eof_q       <= 1'b0;
            eof_pend_q  <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= 16'd0;
            ts_q        <= '0;
            hsize_q     <= 16'd0;
            vsize_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            word_cnt_q  <= word_cnt_d;
            cell_cnt_q  <= cell_cnt_d;
            chunk_len_q <= chunk_len_d;
            has_more_q  <= has_more_d;
            asm_q       <= asm_d;
            info_q      <= info_d;
            valid_q     <= valid_d;
            eof_q       <= eof_d;
            eof_pend_q  <= eof_pend_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            ts_q        <= ts_d;
            hsize_q     <= hsize_d;
            vsize_q     <= vsize_d;
        end
    end

    assign target_info  = info_q;
    assign target_valid = valid_q;
    assign target_eof   = eof_q;
    assign timestamp    = ts_q;
    assign hsize        = hsize_q;
    assign vsize        = vsize_q;
    assign err_pulse    = err_q;
    assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_target_unpacket.sv
// Scenario bench for target_unpacket: scoreboard of expected records and eof markers,
// consumed by a monitor as the DUT hands them off.
module tb_target_unpacket;

    localparam logic [31:0] SYNC = 32'h1aa1_1ff1;

    logic         aclk;
    logic         aresetn;
    logic [31:0]  packet_tdata;
    logic         packet_tvalid;
    logic         packet_tlast;
    logic         packet_tready;
    logic [127:0] target_info;
    logic         target_valid;
    logic         target_ready;
    logic         target_eof;
    logic [31:0]  timestamp;
    logic [15:0]  hsize;
    logic [15:0]  vsize;
    logic         err_pulse;
    logic [15:0]  err_count;

    typedef struct packed {
        logic         is_eof;
        logic [127:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   err_seen = 0;
    int   exp_err  = 0;

    target_unpacket dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .packet_tdata  (packet_tdata),
        .packet_tvalid (packet_tvalid),
        .packet_tlast  (packet_tlast),
        .packet_tready (packet_tready),
        .target_info   (target_info),
        .target_valid  (target_valid),
        .target_ready  (target_ready),
        .target_eof    (target_eof),
        .timestamp     (timestamp),
        .hsize         (hsize),
        .vsize         (vsize),
        .err_pulse     (err_pulse),
        .err_count     (err_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Monitor: sample mid-cycle, match hand-offs and eof pulses against the scoreboard.
    always @(negedge aclk) begin
        #2;
        if (aresetn) begin
            if (err_pulse) err_seen++;
            if (target_eof) begin
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL eof_order: got eof, required nothing (scoreboard empty)");
                end else if (!exp_q[0].is_eof) begin
                    $display("FAIL eof_order: got eof, required record %h", exp_q[0].data);
                    void'(exp_q.pop_front());
                end else begin
                    pass_cnt++;
                    void'(exp_q.pop_front());
                end
            end
            if (target_valid && target_ready) begin
                chk_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL record: got %h, required nothing (scoreboard empty)", target_info);
                end else if (exp_q[0].is_eof || (exp_q[0].data !== target_info)) begin
                    $display("FAIL record: got %h, required %h (eof=%0b)", target_info, exp_q[0].data, exp_q[0].is_eof);
                    void'(exp_q.pop_front());
                end else begin
                    pass_cnt++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic last);
        int waits;
        bit done;
        waits = 0;
        done  = 1'b0;
        @(negedge aclk);
        packet_tvalid = 1'b1;
        packet_tdata  = d;
        packet_tlast  = last;
        while (!done) begin
            #1;
            if (packet_tready === 1'b1) begin
                @(posedge aclk);
                done = 1'b1;
            end else begin
                waits++;
                if (waits > 1000) begin
                    chk_cnt++;
                    $display("FAIL send_timeout: packet_tready=%b after %0d cycles, required 1", packet_tready, waits);
                    done = 1'b1;
                end else begin
                    @(negedge aclk);
                end
            end
        end
    endtask

    task automatic idle();
        @(negedge aclk);
        packet_tvalid = 1'b0;
        packet_tlast  = 1'b0;
    endtask

    task automatic send_header(input logic [31:0] ts, input logic [15:0] len, input logic more,
                               input logic [15:0] hs, input logic [15:0] vs, input logic last3);
        send_word(SYNC, 1'b0);
        send_word(ts, 1'b0);
        send_word({15'd0, more, len}, 1'b0);
        send_word({hs, vs}, last3);
    endtask

    task automatic send_cell(input logic [127:0] c, input logic last);
        for (int k = 0; k < 4; k++) begin
            send_word(c[k*32 +: 32], last && (k == 3));
        end
    endtask

    function automatic logic [127:0] rand_cell();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push_rec(input logic [127:0] c);
        exp_t e;
        e.is_eof = 1'b0;
        e.data   = c;
        exp_q.push_back(e);
    endtask

    task automatic push_eof();
        exp_t e;
        e.is_eof = 1'b1;
        e.data   = '0;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int waits;
        waits = 0;
        while ((exp_q.size() != 0) && (waits < 2000)) begin
            @(negedge aclk);
            waits++;
        end
        chk_cnt++;
        if (exp_q.size() != 0) begin
            $display("FAIL %s_drain: %0d outstanding items, required 0", name, exp_q.size());
            exp_q.delete();
        end else begin
            pass_cnt++;
        end
        repeat (6) @(negedge aclk);
        chk_cnt++;
        if ((err_seen != exp_err) || (err_count !== 16'(exp_err))) begin
            $display("FAIL %s_errors: err_pulses=%0d err_count=%0d, required %0d", name, err_seen, err_count, exp_err);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_reset();
        aresetn       = 1'b0;
        packet_tvalid = 1'b0;
        packet_tdata  = 32'd0;
        packet_tlast  = 1'b0;
        target_ready  = 1'b1;
        repeat (3) @(negedge aclk);
        #2;
        chk_cnt++;
        if (packet_tready !== 1'b0 || target_valid !== 1'b0 || target_eof !== 1'b0 || err_pulse !== 1'b0) begin
            $display("FAIL reset_ctrl: tready=%b valid=%b eof=%b err=%b, required 0 0 0 0",
                     packet_tready, target_valid, target_eof, err_pulse);
        end else begin
            pass_cnt++;
        end
        chk_cnt++;
        if (err_count !== 16'd0 || timestamp !== 32'd0 || hsize !== 16'd0 || vsize !== 16'd0 || target_info !== 128'd0) begin
            $display("FAIL reset_data: err_count=%h ts=%h hsize=%h vsize=%h info=%h, required all zero",
                     err_count, timestamp, hsize, vsize, target_info);
        end else begin
            pass_cnt++;
        end
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        #2;
        chk_cnt++;
        if (packet_tready !== 1'b1) begin
            $display("FAIL reset_release_tready: got %b, required 1", packet_tready);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_basic();
        logic [127:0] a;
        logic [127:0] b;
        a = rand_cell();
        b = rand_cell();
        push_rec(a);
        push_rec(b);
        push_eof();
        send_header(32'h1234_5678, 16'd2, 1'b0, 16'd1920, 16'd1080, 1'b0);
        send_cell(a, 1'b0);
        send_cell(b, 1'b1);
        idle();
        drain("basic");
        chk_cnt++;
        if (timestamp !== 32'h1234_5678 || hsize !== 16'h0780 || vsize !== 16'h0438) begin
            $display("FAIL basic_header: ts=%h hsize=%h vsize=%h, required 12345678 0780 0438", timestamp, hsize, vsize);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] cells[$];
        for (int i = 0; i < 93; i++) begin
            cells.push_back(rand_cell());
            push_rec(cells[i]);
        end
        push_eof();
        send_header(32'hAAAA_0001, 16'd90, 1'b1, 16'd640, 16'd480, 1'b0);
        for (int i = 0; i < 90; i++) send_cell(cells[i], i == 89);
        send_header(32'hAAAA_0002, 16'd3, 1'b0, 16'd640, 16'd480, 1'b0);
        for (int i = 90; i < 93; i++) send_cell(cells[i], i == 92);
        idle();
        drain("back_to_back");
        chk_cnt++;
        if (timestamp !== 32'hAAAA_0002) begin
            $display("FAIL b2b_timestamp: got %h, required aaaa0002", timestamp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_header_only();
        push_eof();
        send_header(32'h0BAD_F00D, 16'd0, 1'b0, 16'd16, 16'd8, 1'b1);
        idle();
        #2;
        chk_cnt++;
        if (target_eof !== 1'b1 || target_valid !== 1'b0) begin
            $display("FAIL hdr_only_eof: eof=%b valid=%b one cycle after tlast, required 1 0", target_eof, target_valid);
        end else begin
            pass_cnt++;
        end
        drain("header_only");
        chk_cnt++;
        if (hsize !== 16'd16 || vsize !== 16'd8) begin
            $display("FAIL hdr_only_size: hsize=%h vsize=%h, required 0010 0008", hsize, vsize);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic test_stall();
        logic [127:0] cells[4];
        for (int i = 0; i < 4; i++) begin
            cells[i] = rand_cell();
            push_rec(cells[i]);
        end
        push_eof();
        fork
            begin
                send_header(32'h5555_0000, 16'd4, 1'b0, 16'd32, 16'd32, 1'b0);
                for (int i = 0; i < 4; i++) send_cell(cells[i], i == 3);
                idle();
            end
            begin
                repeat (6) @(negedge aclk);
                target_ready = 1'b0;
                repeat (12) @(negedge aclk);
                #2;
                chk_cnt++;
                if (packet_tready !== 1'b0 || packet_tvalid !== 1'b1 || target_valid !== 1'b1) begin
                    $display("FAIL stall_backpressure: tready=%b tvalid=%b valid=%b, required 0 1 1",
                             packet_tready, packet_tvalid, target_valid);
                end else begin
                    pass_cnt++;
                end
                repeat (8) @(negedge aclk);
                target_ready = 1'b1;
            end
        join
        drain("stall");
    endtask

    task automatic test_garbage_and_len_err();
        logic [127:0] c;
        for (int i = 0; i < 3; i++) send_word(32'hDEAD_BEEF, i == 2);
        idle();
        repeat (3) @(negedge aclk);
        #2;
        chk_cnt++;
        if (err_seen != 0 || err_count !== 16'd0) begin
            $display("FAIL garbage_silent: err_pulses=%0d err_count=%0d, required 0 0", err_seen, err_count);
        end else begin
            pass_cnt++;
        end
        send_header(32'h0000_0095, 16'd95, 1'b0, 16'd1, 16'd1, 1'b0);
        send_word(32'h1111_1111, 1'b0);
        send_word(32'h2222_2222, 1'b1);
        idle();
        exp_err++;
        drain("len_err");
        chk_cnt++;
        if (err_count !== 16'd1) begin
            $display("FAIL len_err_count: got %0d, required 1", err_count);
        end else begin
            pass_cnt++;
        end
        send_word(SYNC, 1'b1);
        idle();
        exp_err++;
        drain("sync_tlast");
        c = rand_cell();
        push_rec(c);
        push_eof();
        send_header(32'h0000_0096, 16'd1, 1'b0, 16'd2, 16'd3, 1'b0);
        send_cell(c, 1'b1);
        idle();
        drain("after_drop");
    endtask

    task automatic test_early_tlast();
        logic [127:0] c0;
        logic [127:0] c1;
        logic [127:0] c2;
        c0 = rand_cell();
        c1 = rand_cell();
        c2 = rand_cell();
        push_rec(c0);
        send_header(32'h0000_0E01, 16'd3, 1'b0, 16'd4, 16'd4, 1'b0);
        send_cell(c0, 1'b0);
        send_word(c1[31:0], 1'b0);
        send_word(c1[63:32], 1'b1);
        idle();
        exp_err++;
        drain("early_tlast");
        push_rec(c2);
        push_eof();
        send_header(32'h0000_0E02, 16'd1, 1'b0, 16'd5, 16'd6, 1'b0);
        send_cell(c2, 1'b1);
        idle();
        drain("recover");
        chk_cnt++;
        if (timestamp !== 32'h0000_0E02 || hsize !== 16'd5 || vsize !== 16'd6) begin
            $display("FAIL recover_header: ts=%h hsize=%h vsize=%h, required 00000e02 0005 0006", timestamp, hsize, vsize);
        end else begin
            pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_header_only();
        test_stall();
        test_garbage_and_len_err();
        test_early_tlast();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
